// File: rtl/ring_pkg.sv
// Shared types and constants for the ring slot scheduler and its arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ring_pkg;

    typedef enum logic {
        S_WAIT = 1'b0,
        S_BUSY = 1'b1
    } sched_state_t;

    localparam int REQ_RTR_CP = 0;
    localparam int REQ_TRF_DP = 1;

    // Effective ring size: a ring of zero nodes behaves as a ring of one.
    function automatic logic [15:0] max_eff_f(input logic [15:0] max_node);
        return (max_node == 16'd0) ? 16'd1 : max_node;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or above rr_ptr, wrapping.
// Latency: combinational.
// Backpressure: none; pick is zero when no request is set.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] pick
);

    logic found;

    // Walk offsets from the pointer; the first requester hit wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (i == ((int'(rr_ptr) + off) % NREQ))) begin
                    pick[i] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ring_slot_scheduler.sv
// TDMA slot scheduler: tracks the ring slot and grants one local requester TX in this node's slot.
// Latency: request seen at own-slot cycle 0 -> grant registered at slot cycle 1.
// Backpressure: level req held by user; grant held until done/req drop or revoked (abort) at slot end.
module ring_slot_scheduler
    import ring_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int SLOT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     node_id,
    input  logic [15:0]     max_node,
    input  logic            enable,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    output logic [NREQ-1:0] grant,
    output logic            abort,
    output logic [15:0]     slot_index,
    output logic [15:0]     slot_cycle,
    output logic            own_slot,
    output logic            busy
);

    localparam int          PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] LAST_CYC = 16'(SLOT_CYCLES - 1);

    sched_state_t    state_q, state_d;
    logic [15:0]     slot_index_q, slot_index_d;
    logic [15:0]     slot_cycle_q, slot_cycle_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            abort_q, abort_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

    logic [15:0]     max_eff;
    logic            slot_wrap;
    logic [16:0]     slot_next;
    logic [NREQ-1:0] pick;
    logic            release_hit;
    logic [PW-1:0]   ptr_after;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr_arbiter (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .pick   (pick)
    );

    assign max_eff     = max_eff_f(max_node);
    // A node outside the current ring never owns a slot, even if a stale slot_index matches it.
    assign own_slot    = (slot_index_q == node_id) && (node_id < max_eff);
    assign busy        = (state_q == S_BUSY);
    assign grant       = grant_q;
    assign abort       = abort_q;
    assign slot_index  = slot_index_q;
    assign slot_cycle  = slot_cycle_q;
    // Granted user either reports completion or withdraws its request.
    assign release_hit = |(grant_q & (done | ~req));

    // Slot counters; slot_index only moves at the slot boundary, in 17 bits to avoid overflow.
    always_comb begin
        slot_wrap    = (slot_cycle_q == LAST_CYC);
        slot_next    = {1'b0, slot_index_q} + 17'd1;
        slot_cycle_d = slot_wrap ? 16'd0 : slot_cycle_q + 16'd1;
        slot_index_d = slot_index_q;
        if (slot_wrap) begin
            slot_index_d = (slot_next >= {1'b0, max_eff}) ? 16'd0 : slot_next[15:0];
        end
    end

    // Round-robin pointer moves to the requester after the one currently granted.
    always_comb begin
        ptr_after = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                ptr_after = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    // Grant FSM: one grant per own slot, released by the user or revoked at slot end.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        abort_d  = 1'b0;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            S_WAIT: begin
                if (own_slot && (slot_cycle_q == 16'd0) && enable && (|req)) begin
                    grant_d = pick;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (release_hit) begin
                    grant_d  = '0;
                    rr_ptr_d = ptr_after;
                    state_d  = S_WAIT;
                end else if (slot_wrap) begin
                    grant_d  = '0;
                    abort_d  = 1'b1;
                    rr_ptr_d = ptr_after;
                    state_d  = S_WAIT;
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_WAIT;
            end
        endcase
    end

    // State registers; reset clears everything without an abort pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_WAIT;
            slot_index_q <= '0;
            slot_cycle_q <= '0;
            grant_q      <= '0;
            abort_q      <= 1'b0;
            rr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            slot_index_q <= slot_index_d;
            slot_cycle_q <= slot_cycle_d;
            grant_q      <= grant_d;
            abort_q      <= abort_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_ring_slot_scheduler.sv
// Randomized bench for ring_slot_scheduler against a cycle-level behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ring_slot_scheduler;

    localparam int NREQ = 2;
    localparam int SC   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [15:0]     node_id, max_node;
    logic            enable;
    logic [NREQ-1:0] req, done, grant;
    logic            abort;
    logic [15:0]     slot_index, slot_cycle;
    logic            own_slot, busy;

    always #5 clk = ~clk;

    ring_slot_scheduler #(.NREQ(NREQ), .SLOT_CYCLES(SC)) dut (
        .clk        (clk),
        .rst        (rst),
        .node_id    (node_id),
        .max_node   (max_node),
        .enable     (enable),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .abort      (abort),
        .slot_index (slot_index),
        .slot_cycle (slot_cycle),
        .own_slot   (own_slot),
        .busy       (busy)
    );

    int chk_cnt = 0;
    int err_cnt = 0;

    // Reference state: slot position, granted requester (-1 none), pointer, abort pulse.
    int m_slot, m_cyc, m_g, m_rr;
    bit m_abort;

    // Stimulus policy.
    int cfg_node, cfg_max;
    bit rand_req;
    int p_tog;
    int p_done;
    bit en_rand;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_slot  = 0;
        m_cyc   = 0;
        m_g     = -1;
        m_rr    = 0;
        m_abort = 1'b0;
    endtask

    function automatic int eff_size(input int m);
        return (m == 0) ? 1 : m;
    endfunction

    function automatic bit model_own(input int node, input int maxn);
        return (m_slot == node) && (node < eff_size(maxn));
    endfunction

    task automatic compare_outputs();
        logic [31:0] exp_grant;
        exp_grant = (m_g < 0) ? 32'd0 : (32'd1 << m_g);
        check_eq("slot_index", 32'(slot_index), 32'(m_slot));
        check_eq("slot_cycle", 32'(slot_cycle), 32'(m_cyc));
        check_eq("own_slot",   32'(own_slot),   32'(model_own(int'(node_id), int'(max_node))));
        check_eq("grant",      32'(grant),      exp_grant);
        check_eq("abort",      32'(abort),      32'(m_abort));
        check_eq("busy",       32'(busy),       32'(m_g >= 0));
    endtask

    // Advance the model by one clock edge using the inputs just driven.
    task automatic model_edge(input bit r);
        int me;
        if (r) begin
            model_reset();
            return;
        end
        me      = eff_size(int'(max_node));
        m_abort = 1'b0;
        if (m_g < 0) begin
            if (model_own(int'(node_id), int'(max_node)) && m_cyc == 0 && enable && req != '0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_g < 0 && req[(m_rr + k) % NREQ]) m_g = (m_rr + k) % NREQ;
                end
            end
        end else if (done[m_g] || !req[m_g]) begin
            m_rr = (m_g + 1) % NREQ;
            m_g  = -1;
        end else if (m_cyc == SC - 1) begin
            m_rr    = (m_g + 1) % NREQ;
            m_g     = -1;
            m_abort = 1'b1;
        end
        if (m_cyc == SC - 1) begin
            m_cyc  = 0;
            m_slot = (m_slot + 1 >= me) ? 0 : m_slot + 1;
        end else begin
            m_cyc++;
        end
    endtask

    // One clock: check outputs at negedge, drive new inputs, predict the next edge.
    task automatic step(input bit r);
        @(negedge clk);
        compare_outputs();
        rst      = r;
        node_id  = 16'(cfg_node);
        max_node = 16'(cfg_max);
        for (int i = 0; i < NREQ; i++) begin
            if (rand_req && $urandom_range(p_tog - 1) == 0) req[i] = ~req[i];
            done[i] = (p_done > 0) && ($urandom_range(p_done - 1) == 0);
        end
        if (en_rand) enable = ($urandom_range(3) != 0);
        model_edge(r);
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step(1'b0);
    endtask

    initial begin
        int guard;
        rst = 1'b1; cfg_node = 2; cfg_max = 4;
        node_id = 16'd2; max_node = 16'd4; enable = 1'b1;
        req = '0; done = '0;
        rand_req = 1'b0; p_tog = 8; p_done = 0; en_rand = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_slot_index", 32'(slot_index), 32'd0);
        check_eq("rst_grant",      32'(grant),      32'd0);
        check_eq("rst_abort",      32'(abort),      32'd0);
        check_eq("rst_busy",       32'(busy),       32'd0);

        // Slot wrap with no requests; own slot is slot 2.
        run(24);
        // Single requester, random done pulses.
        req = 2'b01; p_done = 6; run(40);
        // Both requesting, round-robin alternation.
        req = 2'b11; p_done = 3; run(60);
        // Requester 1 never done: timeouts.
        req = 2'b10; p_done = 0; run(40);
        // Fully random traffic.
        rand_req = 1'b1; p_done = 6; run(400);
        // Ring of zero nodes: node 0 owns every slot.
        cfg_node = 0; cfg_max = 0; run(120);
        // Random enable.
        cfg_node = 1; cfg_max = 3; en_rand = 1'b1; run(200);
        en_rand = 1'b0; enable = 1'b1;
        // Node outside the ring.
        cfg_node = 5; cfg_max = 3; run(60);
        // Ring shrinks while slot_index is above the new size.
        cfg_node = 6; cfg_max = 8;
        guard = 0;
        while (!(m_slot >= 5 && m_cyc == 1) && guard < 200) begin
            step(1'b0);
            guard++;
        end
        check_eq("shrink_reach_slot5", 32'(guard < 200), 32'd1);
        cfg_max = 3; run(60);
        // Reset while a grant is held.
        cfg_node = 0; cfg_max = 2; rand_req = 1'b0; req = 2'b01; p_done = 0;
        guard = 0;
        while (m_g < 0 && guard < 100) begin
            step(1'b0);
            guard++;
        end
        check_eq("grant_before_rst", 32'(guard < 100), 32'd1);
        step(1'b1);
        run(20);
        // Random traffic with occasional resets.
        rand_req = 1'b1; p_done = 5; cfg_node = 1; cfg_max = 2;
        for (int c = 0; c < 300; c++) step($urandom_range(39) == 0);
        step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
